// File: rtl/board_io_ctrl.sv
// ============================================================================
//  Module   : board_io_ctrl
//  Purpose  : Front-panel I/O: 2-flop sync, counter debounce and edge pulses
//             on the raw inputs; per-LED off/follow/blink/PWM drive.
//  Options  : BOARD_IO_PWM_EN builds the PWM counter (otherwise mode 11 = follow)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module board_io_ctrl #(
   parameter int N_IN            = 8,
   parameter int N_LED           = 8,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int PWM_BITS        = 8,
   parameter int BLINK_DIV_LOG2  = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN-1:0]       in_raw,
   output logic [N_IN-1:0]       in_level,
   output logic [N_IN-1:0]       in_rise,
   output logic [N_IN-1:0]       in_fall,
   input  logic [N_LED-1:0]      led_src,
   input  logic [2*N_LED-1:0]    led_mode,
   input  logic [PWM_BITS-1:0]   led_duty,
   output logic [N_LED-1:0]      led_out
);

   localparam int                    C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [C_CNT_W-1:0]    C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [C_CNT_W-1:0]    C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [BLINK_DIV_LOG2-1:0] C_BLINK_ONE = BLINK_DIV_LOG2'(1);

   logic [N_IN-1:0]            r_s1;
   logic [N_IN-1:0]            r_s2;
   logic [BLINK_DIV_LOG2-1:0]  r_blink_cnt;
   logic                       w_blink_phase;
   logic                       w_pwm_on;
   logic [N_LED-1:0]           w_led_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= in_raw;
         r_s2 <= r_s1;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYCLES consecutive
   // mismatching samples; any agreeing sample restarts the count.
   for (genvar i = 0; i < N_IN; i++) begin : g_debounce
      logic [C_CNT_W-1:0] r_cnt;
      logic               r_level;
      logic               r_rise;
      logic               r_fall;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2[i] == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
               r_cnt   <= '0;
               r_level <= r_s2[i];
               r_rise  <= r_s2[i];
               r_fall  <= ~r_s2[i];
            end else begin
               r_cnt <= r_cnt + C_CNT_ONE;
            end
         end
      end

      assign in_level[i] = r_level;
      assign in_rise[i]  = r_rise;
      assign in_fall[i]  = r_fall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_blink_cnt <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + C_BLINK_ONE;
      end
   end

   assign w_blink_phase = r_blink_cnt[BLINK_DIV_LOG2-1];

`ifdef BOARD_IO_PWM_EN
   localparam logic [PWM_BITS-1:0] C_PWM_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] r_pwm_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + C_PWM_ONE;
      end
   end

   assign w_pwm_on = (r_pwm_cnt < led_duty);
`else
   // Without PWM the duty input has no consumer; mode 11 degenerates to follow.
   logic w_unused_duty;
   assign w_unused_duty = ^led_duty;
   assign w_pwm_on      = 1'b1;
`endif

   always_comb begin
      w_led_next = '0;
      for (int i = 0; i < N_LED; i++) begin
         case (led_mode[2*i +: 2])
            2'b00:   w_led_next[i] = 1'b0;
            2'b01:   w_led_next[i] = led_src[i];
            2'b10:   w_led_next[i] = led_src[i] & w_blink_phase;
            default: w_led_next[i] = led_src[i] & w_pwm_on;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_out <= '0;
      end else begin
         led_out <= w_led_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
// ============================================================================
//  Module   : tb_board_io_ctrl
//  Purpose  : Self-checking bench for board_io_ctrl (reference model + directed
//             and random stimulus). Honours BOARD_IO_PWM_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_io_ctrl;

   localparam int N_IN     = 4;
   localparam int N_LED    = 4;
   localparam int DC       = 4;
   localparam int PWM_BITS = 3;
   localparam int BLINK    = 3;

   logic                 clk      = 1'b0;
   logic                 reset    = 1'b1;
   logic [N_IN-1:0]      in_raw   = '0;
   logic [N_LED-1:0]     led_src  = '0;
   logic [2*N_LED-1:0]   led_mode = '0;
   logic [PWM_BITS-1:0]  led_duty = '0;
   logic [N_IN-1:0]      in_level;
   logic [N_IN-1:0]      in_rise;
   logic [N_IN-1:0]      in_fall;
   logic [N_LED-1:0]     led_out;

   int checks = 0;
   int errors = 0;

   board_io_ctrl #(
      .N_IN(N_IN), .N_LED(N_LED), .DEBOUNCE_CYCLES(DC),
      .PWM_BITS(PWM_BITS), .BLINK_DIV_LOG2(BLINK)
   ) dut (
      .clk(clk), .reset(reset), .in_raw(in_raw),
      .in_level(in_level), .in_rise(in_rise), .in_fall(in_fall),
      .led_src(led_src), .led_mode(led_mode), .led_duty(led_duty),
      .led_out(led_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: a level flips once the last DC synchronised samples
   // (since reset) all disagree with it; LEDs derive from cycles since reset.
   bit             hist [N_IN][DC];
   int             hv   [N_IN];
   logic [N_IN-1:0]  m_s1, m_s2, m_level, m_rise, m_fall;
   logic [N_LED-1:0] m_led;
   int             m_cyc;
   bit             run_ok;
   bit             ph;
   int             pw;

   initial begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_led = '0; m_cyc = 0;
      for (int i = 0; i < N_IN; i++) hv[i] = 0;
   end

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_led = '0; m_cyc = 0;
         for (int i = 0; i < N_IN; i++) hv[i] = 0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            for (int j = DC - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = m_s2[i];
            if (hv[i] < DC) hv[i]++;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            run_ok = (hv[i] == DC);
            for (int j = 0; j < DC; j++) if (hist[i][j] == m_level[i]) run_ok = 0;
            if (run_ok) begin
               m_level[i] = ~m_level[i];
               m_rise[i]  = m_level[i];
               m_fall[i]  = ~m_level[i];
            end
         end
         ph = (m_cyc % (1 << BLINK)) >= (1 << (BLINK - 1));
         pw = m_cyc % (1 << PWM_BITS);
         for (int i = 0; i < N_LED; i++) begin
            case (led_mode[2*i +: 2])
               2'b00: m_led[i] = 1'b0;
               2'b01: m_led[i] = led_src[i];
               2'b10: m_led[i] = led_src[i] & ph;
               default: begin
`ifdef BOARD_IO_PWM_EN
                  m_led[i] = led_src[i] & (pw < int'(led_duty));
`else
                  m_led[i] = led_src[i];
`endif
               end
            endcase
         end
         m_cyc++;
         m_s2 = m_s1;
         m_s1 = in_raw;
      end
   end

   always @(negedge clk) begin
      chk("model_level", in_level, m_level);
      chk("model_rise",  in_rise,  m_rise);
      chk("model_fall",  in_fall,  m_fall);
      chk("model_led",   led_out,  m_led);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, cnt2, viol;
      logic s [16];

      // Reset with inputs high, then first-level latency
      reset  = 1'b1;
      in_raw = 4'hF;
      repeat (3) begin
         tick();
         chk("rst_outputs", {in_level, in_rise, in_fall, led_out}, 32'h0);
      end
      reset = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         tick();
         if (n < 6) chk("pre_level", in_level, 4'h0);
         else begin
            chk("level_F", in_level, 4'hF);
            chk("rise_F",  in_rise,  4'hF);
         end
      end
      tick();
      chk("rise_single", in_rise, 4'h0);

      // Glitch shorter than the debounce window
      in_raw = 4'hE;
      repeat (8) tick();
      chk("level_E", in_level, 4'hE);
      in_raw = 4'hF;
      repeat (3) tick();
      in_raw = 4'hE;
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(in_rise[0]); end
      chk("glitch_rise", cnt, 0);
      chk("glitch_level", in_level[0], 1'b0);
      in_raw = 4'hF;
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(in_rise[0]); end
      chk("hold_rise", cnt, 1);
      chk("hold_level", in_level[0], 1'b1);

      // Simultaneous falls on bits 0 and 2
      in_raw = 4'hA;
      cnt = 0; cnt2 = 0; viol = 0;
      repeat (10) begin
         tick();
         if (in_fall == 4'b0101) cnt++;
         else if (in_fall != 4'b0000) viol++;
         if (in_rise != 4'b0000) cnt2++;
      end
      chk("fall_pair", cnt, 1);
      chk("fall_other", viol, 0);
      chk("fall_no_rise", cnt2, 0);
      chk("fall_level", in_level, 4'hA);

      // Blink on LED1: 4 high / 4 low
      led_mode = 8'b00_00_10_00;
      led_src  = 4'b0010;
      repeat (2) tick();
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
         tick();
         s[j] = led_out[1];
         cnt += int'(led_out[1]);
      end
      viol = 0;
      for (int j = 0; j < 12; j++) if (s[j] == s[j+4]) viol++;
      chk("blink_high", cnt, 8);
      chk("blink_period", viol, 0);
      led_src = 4'b0000;
      repeat (2) tick();
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(led_out[1]); end
      chk("blink_src0", cnt, 0);

      // PWM on LED2
      led_mode = 8'b00_11_00_00;
      led_src  = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         int d;
         d = (k == 0) ? 0 : (k == 1) ? 3 : 7;
         led_duty = PWM_BITS'(d);
         repeat (2) tick();
         cnt = 0;
         repeat (8) begin tick(); cnt += int'(led_out[2]); end
`ifdef BOARD_IO_PWM_EN
         chk("pwm_duty", cnt, d);
`else
         chk("pwm_follow", cnt, 8);
`endif
      end

      // Reset on the edge where the count would complete
      reset  = 1'b1;
      in_raw = 4'h0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      in_raw = 4'h1;
      repeat (5) tick();
      reset  = 1'b1;
      in_raw = 4'h0;
      tick();
      chk("midrst_rise",  in_rise,  4'h0);
      chk("midrst_level", in_level, 4'h0);
      reset = 1'b0;
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(in_rise != 4'h0); end
      chk("midrst_after", cnt, 0);
      chk("midrst_level2", in_level, 4'h0);

      // Randomised phase checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < N_IN; b++)
            if ($urandom_range(0, 11) == 0) in_raw[b] = ~in_raw[b];
         led_src = N_LED'($urandom);
         if ((c % 16) == 0) begin
            led_mode = (2*N_LED)'($urandom);
            led_duty = PWM_BITS'($urandom);
         end
      end
      reset = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
